// File: rtl/rat_io_port_bank_if.sv
`default_nettype none
// ============================================================================
// rat_io_port_bank_if : RAT MCU port bus (PORT_ID/OUT_PORT/IO_STRB/IN_PORT)
// Rev 1.0
// ============================================================================
interface rat_io_port_bank_if #(
    parameter int DATA_W = 8
) ();
    logic [7:0]        port_id;
    logic [DATA_W-1:0] out_port;
    logic              io_strb;
    logic [DATA_W-1:0] in_port;

    modport master (output port_id, output out_port, output io_strb, input  in_port);
    modport slave  (input  port_id, input  out_port, input  io_strb, output in_port);
endinterface
`default_nettype wire

// File: rtl/rat_io_port_bank.sv
`default_nettype none
// ============================================================================
// rat_io_port_bank : output registers, synchronised inputs and change-detect
// interrupt controller on the RAT MCU port bus.   Rev 1.0
// ============================================================================
module rat_io_port_bank #(
    parameter int         DATA_W      = 8,
    parameter int         N_OUT       = 4,
    parameter int         N_IN        = 4,
    parameter logic [7:0] OUT_BASE    = 8'h40,
    parameter logic [7:0] IN_BASE     = 8'h20,
    parameter logic [7:0] MASK_ID     = 8'hF0,
    parameter logic [7:0] PEND_ID     = 8'hF1,
    parameter int         SYNC_STAGES = 2
) (
    input  wire logic                    clk,
    input  wire logic                    reset_n,
    rat_io_port_bank_if.slave            bus,
    input  wire logic [N_IN*DATA_W-1:0]  in_data,
    output logic      [N_OUT*DATA_W-1:0] out_data,
    output logic      [N_OUT-1:0]        out_wr,
    output logic                         intr
);
    function automatic bit ranges_overlap(int a, int an, int b, int bn);
        return (a < b + bn) && (b < a + an);
    endfunction

    localparam bit BAD_MAP =
        ranges_overlap(int'(OUT_BASE), N_OUT, int'(IN_BASE), N_IN) ||
        ranges_overlap(int'(OUT_BASE), N_OUT, int'(MASK_ID), 1)    ||
        ranges_overlap(int'(OUT_BASE), N_OUT, int'(PEND_ID), 1)    ||
        ranges_overlap(int'(IN_BASE),  N_IN,  int'(MASK_ID), 1)    ||
        ranges_overlap(int'(IN_BASE),  N_IN,  int'(PEND_ID), 1)    ||
        (MASK_ID == PEND_ID);

    if (BAD_MAP) begin : g_bad_map
        $error("rat_io_port_bank: port ID ranges overlap");
    end
    if (N_IN > DATA_W) begin : g_bad_nin
        $error("rat_io_port_bank: N_IN must not exceed DATA_W");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("rat_io_port_bank: SYNC_STAGES must be at least 2");
    end

    localparam int SETTLE_MAX = SYNC_STAGES + 1;
    localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

    logic [SYNC_STAGES-1:0][N_IN*DATA_W-1:0] sync_q;
    logic [N_IN*DATA_W-1:0]                  sync_w;
    logic [N_IN*DATA_W-1:0]                  prev_q;
    logic [CNT_W-1:0]                        settle_cnt;
    logic                                    settled;
    logic [N_IN-1:0]                         mask;
    logic [N_IN-1:0]                         pending;
    logic [N_IN-1:0]                         chg;
    logic [N_IN-1:0]                         pend_set;
    logic [N_IN-1:0]                         pend_clr;
    logic [N_OUT-1:0]                        wr_hit;
    logic                                    mask_wr;
    logic [DATA_W-1:0]                       rd_data;

    assign sync_w  = sync_q[SYNC_STAGES-1];
    assign settled = (settle_cnt == CNT_W'(SETTLE_MAX));

    always_comb begin
        wr_hit   = '0;
        chg      = '0;
        for (int j = 0; j < N_OUT; j++) begin
            wr_hit[j] = bus.io_strb && (bus.port_id == 8'(int'(OUT_BASE) + j));
        end
        for (int i = 0; i < N_IN; i++) begin
            chg[i] = settled && (sync_w[i*DATA_W +: DATA_W] != prev_q[i*DATA_W +: DATA_W]);
        end
        mask_wr  = bus.io_strb && (bus.port_id == MASK_ID);
        pend_set = chg & mask;
        pend_clr = (bus.io_strb && (bus.port_id == PEND_ID)) ? bus.out_port[N_IN-1:0] : '0;
    end

    // Read mux: later matches cannot collide because the ID ranges are disjoint.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (bus.port_id == 8'(int'(IN_BASE) + i)) rd_data = sync_w[i*DATA_W +: DATA_W];
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (bus.port_id == 8'(int'(OUT_BASE) + j)) rd_data = out_data[j*DATA_W +: DATA_W];
        end
        if (bus.port_id == MASK_ID) rd_data[N_IN-1:0] = mask;
        if (bus.port_id == PEND_ID) rd_data[N_IN-1:0] = pending;
    end

    assign bus.in_port = rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            settle_cnt <= '0;
            out_data   <= '0;
            out_wr     <= '0;
            mask       <= '0;
            pending    <= '0;
            intr       <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_data};
            prev_q <= sync_w;
            if (!settled) settle_cnt <= settle_cnt + CNT_W'(1);
            out_wr <= wr_hit;
            for (int j = 0; j < N_OUT; j++) begin
                if (wr_hit[j]) out_data[j*DATA_W +: DATA_W] <= bus.out_port;
            end
            if (mask_wr) mask <= bus.out_port[N_IN-1:0];
            // Set is OR-ed after the clear so a simultaneous new change wins.
            pending <= (pending & ~pend_clr) | pend_set;
            intr    <= |(pending & mask);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rat_io_port_bank.sv
`default_nettype none
// Self-checking bench for rat_io_port_bank: vector table, directed corner
// sequences and randomised traffic against a history-based reference model.
module tb_rat_io_port_bank;
    localparam int         DATA_W      = 8;
    localparam int         N_OUT       = 4;
    localparam int         N_IN        = 4;
    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] OUT_BASE    = 8'h40;
    localparam logic [7:0] IN_BASE     = 8'h20;
    localparam logic [7:0] MASK_ID     = 8'hF0;
    localparam logic [7:0] PEND_ID     = 8'hF1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rat_io_port_bank_if #(.DATA_W(DATA_W)) bus ();
    logic [N_IN*DATA_W-1:0]  in_data;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_wr;
    logic                    intr;

    rat_io_port_bank #(
        .DATA_W(DATA_W), .N_OUT(N_OUT), .N_IN(N_IN),
        .OUT_BASE(OUT_BASE), .IN_BASE(IN_BASE), .MASK_ID(MASK_ID),
        .PEND_ID(PEND_ID), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .in_data(in_data), .out_data(out_data), .out_wr(out_wr), .intr(intr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file plus a history of sampled input words.
    logic [DATA_W-1:0]      m_out [N_OUT];
    logic [N_OUT-1:0]       m_wr;
    logic [N_IN-1:0]        m_mask, m_pend;
    logic                   m_intr;
    logic [N_IN*DATA_W-1:0] hist [$];
    int                     edges;

    task automatic model_reset();
        for (int j = 0; j < N_OUT; j++) m_out[j] = '0;
        m_wr = '0; m_mask = '0; m_pend = '0; m_intr = 1'b0; edges = 0;
        hist.delete();
        repeat (SYNC_STAGES + 1) hist.push_back('0);
    endtask

    // Value visible to the MCU is the input sampled SYNC_STAGES edges ago.
    function automatic logic [N_IN*DATA_W-1:0] m_sync_word(int back);
        return hist[hist.size() - SYNC_STAGES - back];
    endfunction

    function automatic logic [DATA_W-1:0] exp_read(logic [7:0] pid);
        logic [N_IN*DATA_W-1:0] s;
        logic [DATA_W-1:0] r;
        s = m_sync_word(0);
        r = '0;
        for (int i = 0; i < N_IN; i++)  if (pid == 8'(int'(IN_BASE) + i))  r = s[i*DATA_W +: DATA_W];
        for (int j = 0; j < N_OUT; j++) if (pid == 8'(int'(OUT_BASE) + j)) r = m_out[j];
        if (pid == MASK_ID) r = DATA_W'(m_mask);
        if (pid == PEND_ID) r = DATA_W'(m_pend);
        return r;
    endfunction

    task automatic model_edge();
        logic [N_IN*DATA_W-1:0] s, p;
        logic [N_IN-1:0] set, clr;
        s = m_sync_word(0);
        p = m_sync_word(1);
        set = '0;
        if (edges >= SYNC_STAGES + 1)
            for (int i = 0; i < N_IN; i++)
                if (s[i*DATA_W +: DATA_W] != p[i*DATA_W +: DATA_W] && m_mask[i]) set[i] = 1'b1;
        clr = (bus.io_strb && bus.port_id == PEND_ID) ? bus.out_port[N_IN-1:0] : '0;
        m_intr = |(m_pend & m_mask);
        m_pend = (m_pend & ~clr) | set;
        m_wr = '0;
        if (bus.io_strb) begin
            for (int j = 0; j < N_OUT; j++)
                if (bus.port_id == 8'(int'(OUT_BASE) + j)) begin
                    m_out[j] = bus.out_port;
                    m_wr[j]  = 1'b1;
                end
            if (bus.port_id == MASK_ID) m_mask = bus.out_port[N_IN-1:0];
        end
        hist.push_back(in_data);
        if (hist.size() > 8) void'(hist.pop_front());
        if (edges < 1000) edges++;
    endtask

    task automatic check_model();
        logic [N_OUT*DATA_W-1:0] packed_out;
        for (int j = 0; j < N_OUT; j++) packed_out[j*DATA_W +: DATA_W] = m_out[j];
        chk("out_data", out_data, packed_out);
        chk("out_wr", out_wr, m_wr);
        chk("intr", intr, m_intr);
        chk("in_port", bus.in_port, exp_read(bus.port_id));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic set_bus(input logic [7:0] pid, input logic [7:0] data, input logic strb);
        bus.port_id = pid; bus.out_port = data; bus.io_strb = strb;
    endtask

    typedef struct {
        logic [7:0]       pid;
        logic [7:0]       data;
        logic             strb;
        logic [N_OUT-1:0] exp_wr;
        logic [7:0]       exp_rd;
    } vec_t;
    vec_t tbl [10];

    initial begin
        tbl[0] = '{8'h42, 8'hA5, 1'b1, 4'b0100, 8'hA5};
        tbl[1] = '{8'h44, 8'h11, 1'b1, 4'b0000, 8'h00};
        tbl[2] = '{8'h40, 8'h5A, 1'b1, 4'b0001, 8'h5A};
        tbl[3] = '{8'h40, 8'h77, 1'b1, 4'b0001, 8'h77};
        tbl[4] = '{8'h43, 8'hFF, 1'b0, 4'b0000, 8'h00};
        tbl[5] = '{8'hF0, 8'hFE, 1'b1, 4'b0000, 8'h0E};
        tbl[6] = '{8'hF1, 8'hFF, 1'b1, 4'b0000, 8'h00};
        tbl[7] = '{8'h42, 8'h00, 1'b0, 4'b0000, 8'hA5};
        tbl[8] = '{8'h20, 8'h00, 1'b0, 4'b0000, 8'h00};
        tbl[9] = '{8'h3F, 8'h00, 1'b1, 4'b0000, 8'h00};

        in_data = '0;
        set_bus(8'h00, 8'h00, 1'b0);
        model_reset();
        #2;
        chk("reset_out_data", out_data, '0);
        chk("reset_intr", intr, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            set_bus(tbl[k].pid, tbl[k].data, tbl[k].strb);
            cycle();
            chk("tbl_out_wr", out_wr, tbl[k].exp_wr);
            chk("tbl_read", bus.in_port, tbl[k].exp_rd);
        end
        set_bus(8'h00, 8'h00, 1'b0);
        cycle();
        chk("wr_pulse_one_cycle", out_wr, 4'b0000);
        chk("reg2_value", out_data[23:16], 8'hA5);

        // Asynchronous reset with registers loaded: no clock edge required.
        bus.port_id = 8'h40;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_out_data", out_data, '0);
        chk("async_rst_intr", intr, 1'b0);
        chk("async_rst_read40", bus.in_port, 8'h00);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) cycle();

        // Input synchroniser latency.
        in_data[15:8] = 8'h3C;
        bus.port_id = 8'h21;
        cycle();
        chk("sync_edge1", bus.in_port, 8'h00);
        cycle();
        chk("sync_edge2", bus.in_port, 8'h3C);

        // Interrupt flow on port 1.
        set_bus(MASK_ID, 8'h02, 1'b1);
        cycle();
        set_bus(PEND_ID, 8'h00, 1'b0);
        in_data[15:8] = 8'hC3;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("intr_latency", intr, (k == 4));
        end
        chk("pend_read", bus.in_port, 8'h02);
        set_bus(PEND_ID, 8'h02, 1'b1);
        cycle();
        set_bus(PEND_ID, 8'h00, 1'b0);
        chk("pend_cleared", bus.in_port, 8'h00);
        cycle();
        chk("intr_after_clear", intr, 1'b0);
        in_data[7:0] = 8'hFF;
        repeat (6) cycle();
        chk("masked_intr", intr, 1'b0);
        chk("masked_pend", bus.in_port, 8'h00);

        // Set and W1C on the same edge: set wins.
        in_data[15:8] = 8'h3C;
        repeat (4) cycle();
        chk("collision_pre_intr", intr, 1'b1);
        in_data[15:8] = 8'h5A;
        repeat (2) cycle();
        set_bus(PEND_ID, 8'h02, 1'b1);
        cycle();
        set_bus(PEND_ID, 8'h00, 1'b0);
        chk("collision_pend", bus.in_port, 8'h02);
        cycle();
        chk("collision_intr", intr, 1'b1);

        // Reset release with active inputs raises nothing.
        in_data = 32'h1122_3344;
        #2;
        reset_n = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
        set_bus(MASK_ID, 8'h0F, 1'b1);
        cycle();
        set_bus(PEND_ID, 8'h00, 1'b0);
        repeat (8) cycle();
        chk("settle_pend", bus.in_port, 8'h00);
        chk("settle_intr", intr, 1'b0);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] ids [10];
            ids = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h20, 8'h21, 8'h22, 8'h23, MASK_ID, PEND_ID};
            if ($urandom_range(0, 7) == 0)
                set_bus(8'($urandom), 8'($urandom), 1'($urandom));
            else
                set_bus(ids[$urandom_range(0, 9)], 8'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 5) == 0) begin
                int p;
                p = $urandom_range(0, N_IN - 1);
                in_data[p*DATA_W +: DATA_W] = 8'($urandom);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
